ccd_readout_sequencer: RTL

CCD_READOUT_SEQUENCER -- requirements
Module: ccd_readout_sequencer

---
 rtl/ccd_readout_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ccd_readout_sequencer.sv
// rtl/ccd_readout_sequencer.sv - linear CCD clock/gate sequencer with ADC strobe generation
module ccd_readout_sequencer #(
   parameter int NPIX_W = 16,
   parameter int DIV_W  = 8
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              start,
   input  logic              abort,
   input  logic              continuous,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [NPIX_W-1:0] cfg_npix,
   input  logic [7:0]        cfg_sh_len,
   input  logic [15:0]       cfg_integ,
   output logic              ccd_mclk,
   output logic              ccd_sh,
   output logic              ccd_icg,
   output logic              adc_strobe,
   output logic [NPIX_W-1:0] pix_idx,
   output logic              busy,
   output logic              frame_done,
   output logic              cfg_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_ICG, S_SH, S_HOLD, S_READ, S_INTEG, S_DONE
   } state_t;

   localparam logic [DIV_W-1:0]  DIV_ONE = 1;
   localparam logic [NPIX_W-1:0] PIX_ONE = 1;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_cnt, div_hold, div_lim;
   logic              div_wrap, tick;
   logic [NPIX_W-1:0] npix_l, pix_q;
   logic [7:0]        sh_l;
   logic [15:0]       integ_l, tick_cnt, sh_last;
   logic              cont_l, accept, frame_end, pix_last, is_idle, counting;

   assign is_idle  = (state_q == S_IDLE);
   assign accept   = is_idle && start && !abort && (cfg_npix != '0);
   assign div_lim  = is_idle ? cfg_div : div_hold;
   // >= keeps the divider from running away if cfg_div shrinks while idle
   assign div_wrap = (div_cnt >= div_lim);
   assign tick     = div_wrap && !ccd_mclk;
   assign sh_last  = (sh_l == 8'd0) ? 16'd0 : {8'd0, sh_l - 8'd1};
   assign pix_last = (pix_q == npix_l - PIX_ONE);
   assign counting = (state_q == S_ICG) || (state_q == S_SH) || (state_q == S_INTEG);
   assign pix_idx  = pix_q;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         div_cnt  <= '0;
         div_hold <= '0;
         ccd_mclk <= 1'b0;
      end else begin
         if (is_idle) div_hold <= cfg_div;
         if (div_wrap) begin
            div_cnt  <= '0;
            ccd_mclk <= !ccd_mclk;
         end else begin
            div_cnt <= div_cnt + DIV_ONE;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      frame_end = 1'b0;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_ICG;
         S_ICG:   if (tick && tick_cnt == 16'd1) state_d = S_SH;
         S_SH:    if (tick && tick_cnt == sh_last) state_d = S_HOLD;
         S_HOLD:  if (tick) state_d = S_READ;
         S_READ: begin
            if (tick && pix_last) begin
               if (integ_l == 16'd0) frame_end = 1'b1;
               else                  state_d   = S_INTEG;
            end
         end
         S_INTEG: if (tick && tick_cnt == integ_l - 16'd1) frame_end = 1'b1;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (frame_end) state_d = cont_l ? S_ICG : S_DONE;
      if (abort && !is_idle) state_d = S_IDLE;
   end

   always_comb begin
      ccd_sh     = 1'b0;
      ccd_icg    = 1'b1;
      adc_strobe = 1'b0;
      frame_done = 1'b0;
      busy       = !is_idle;
      case (state_q)
         S_ICG, S_HOLD: ccd_icg = 1'b0;
         S_SH: begin
            ccd_icg = 1'b0;
            ccd_sh  = 1'b1;
         end
         S_READ:  adc_strobe = tick;
         S_DONE:  frame_done = !abort;
         default: ;
      endcase
      // continuous mode reports the frame at the re-arm instead of via DONE
      if (frame_end && cont_l && !abort) frame_done = 1'b1;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         npix_l   <= '0;
         sh_l     <= '0;
         integ_l  <= '0;
         cont_l   <= 1'b0;
         tick_cnt <= '0;
         pix_q    <= '0;
         cfg_err  <= 1'b0;
      end else begin
         cfg_err <= is_idle && start && !abort && (cfg_npix == '0);
         if (accept) begin
            npix_l  <= cfg_npix;
            sh_l    <= cfg_sh_len;
            integ_l <= cfg_integ;
            cont_l  <= continuous;
         end
         if (state_d != state_q)
            tick_cnt <= '0;
         else if (tick && counting)
            tick_cnt <= tick_cnt + 16'd1;
         if (state_q == S_HOLD && state_d == S_READ)
            pix_q <= '0;
         else if (state_q == S_READ && state_d == S_READ && tick)
            pix_q <= pix_q + PIX_ONE;
      end
   end

endmodule
